core_ctrl: RTL
==============

Name: core_ctrl

Overview:
- Multi-cycle sequencer for the single-issue RV32I core. Drives the instruction fetch handshake, instruction-register load, data-memory handshake, PC update select, register write-back enable and write-back mux.
- Consumes opcode and wb_reg from the decoder, and the branch condition from ALU result bit 0.
- Sits between the fetch/memory interfaces and the decoder/ALU/register-file datapath.

Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles for imem_ready or dmem_ready before bus error (1..255).
- CNT_W, 8: timeout counter width; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  instruction valid on fetch bus
- ir_we  out  1  load instruction register
- opcode  in  7  opcode of latched IR (decoder)
- wb_reg  in  1  decoder write-back flag
- alu_cond  in  1  ALU result bit 0 (branch taken)
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- dmem_ready  in  1  data access complete
- reg_we  out  1  register file write enable
- wb_sel  out  2  00 ALU, 01 load data, 10 PC+4
- pc_we  out  1  PC write enable
- pc_sel  out  2  00 PC+4, 01 PC+imm, 10 ALU result with bit 0 cleared
- retire  out  1  one-cycle pulse per retired instruction
- instret  out  32  retired-instruction count
- halted  out  1  core stopped
- illegal  out  1  halted due to unsupported opcode
- bus_err  out  1  halted due to memory timeout
- state_o  out  3  current state, for debug

Behaviour:
- States: RST_WAIT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Reset value is RST_WAIT.
- Outputs are Moore/Mealy combinational from state, opcode and ready inputs. All outputs are 0 in RST_WAIT.
- Asynchronous reset at any time forces RST_WAIT, clears instret, timeout counter and sticky flags, and drops every request immediately.
- RST_WAIT: lasts one cycle, then goes to FETCH.
- FETCH: imem_req=1 held until imem_ready. On the imem_ready cycle: ir_we=1, go to DECODE.
- DECODE: one cycle. Supported opcodes are 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011.
  - Any other opcode: go to HALT with illegal=1.
  - 1110011 (SYSTEM): go to HALT with illegal=0.
  - Otherwise: go to EXEC.
- EXEC: one cycle.
  - LOAD/STORE: go to MEM.
  - BRANCH: pc_we=1, pc_sel=01 if alu_cond else 00, retire=1, go to FETCH.
  - FENCE: pc_we=1, pc_sel=00, retire=1, go to FETCH.
  - Otherwise: go to WB.
- MEM: dmem_req=1; dmem_we=1 only for STORE. Wait for dmem_ready.
  - STORE on ready: pc_we=1, pc_sel=00, retire=1, go to FETCH.
  - LOAD on ready: go to WB.
- WB: one cycle. reg_we=wb_reg; pc_we=1; retire=1; go to FETCH.
  - wb_sel: 01 for LOAD, 10 for JAL/JALR, else 00.
  - pc_sel: 01 for JAL, 10 for JALR, else 00.
- Timeout:
  - The counter increments each FETCH/MEM cycle with ready low, and clears on any state change.
  - If ready is low while the counter equals MEM_TIMEOUT-1: go to HALT, bus_err=1, request dropped next cycle.
  - If ready arrives on the limit cycle, ready wins.
- HALT: absorbing until reset. halted=1; illegal/bus_err hold their values; all requests and write enables are 0.
- imem_ready outside FETCH and dmem_ready outside MEM are ignored.
- instret increments on each retire (registered, visible the cycle after the pulse) and wraps 0xFFFFFFFF→0.
- At most one of pc_we-driven retire per instruction; retire never asserts in the same cycle as ir_we.

Test Plan:
- ADDI (opcode 0010011, wb_reg=1), imem_ready on the 1st FETCH cycle → states 1,2,3,5. WB shows reg_we=1, wb_sel=00, pc_sel=00, retire=1. instret=1 next cycle; 4 cycles per instruction.
- BEQ with alu_cond=1, then alu_cond=0 → EXEC gives pc_we=1 with pc_sel=01, then pc_sel=00. reg_we stays 0 in both.
- LW with dmem_ready delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0, then WB with wb_sel=01 and reg_we=1. SW → dmem_we=1, retire on the ready cycle, no WB state.
- JALR → wb_sel=10, pc_sel=10, reg_we=1 in WB. Opcode 1111111 → HALT with illegal=1, halted=1, no retire. ECALL → HALT with illegal=0.
- imem_ready held low, MEM_TIMEOUT=4 → imem_req high exactly 4 cycles, then halted=1 and bus_err=1. Repeat with ready on the 4th cycle → proceeds to DECODE, no error.
- Assert rst_n low while in MEM with dmem_req=1 → dmem_req=0 immediately, instret=0, state_o=0. Release → FETCH after one cycle.

Source files
------------

// File: rtl/core_ctrl.sv
// Multi-cycle sequencer for the single-issue RV32I core: fetch/memory handshakes,
// IR load, PC update select, register write-back control and retire counting.
module core_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        ir_we,
    input  logic [6:0]  opcode,
    input  logic        wb_reg,
    input  logic        alu_cond,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        retire,
    output logic [31:0] instret,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        RST_WAIT = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        EXEC     = 3'd3,
        MEM      = 3'd4,
        WB       = 3'd5,
        HALT     = 3'd6
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              illegal_q;
    logic              bus_err_q;
    logic [31:0]       instret_q;

    logic is_load, is_store, is_branch, is_fence, is_jal, is_jalr, is_system, is_legal;
    logic mem_wait, timeout;

    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_fence  = (opcode == OP_FENCE);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_system = (opcode == OP_SYSTEM);
    assign is_legal  = is_load || is_store || is_branch || is_fence || is_jal || is_jalr ||
                       is_system || (opcode == OP_LUI) || (opcode == OP_AUIPC) ||
                       (opcode == OP_IMM) || (opcode == OP_REG);

    // Handshake: a request stays high until its ready is seen in the same cycle;
    // ready on the limit cycle is accepted, only ready-low at the limit is an error.
    assign mem_wait = ((state == FETCH) && !imem_ready) || ((state == MEM) && !dmem_ready);
    assign timeout  = mem_wait && (wait_cnt == WAIT_LIMIT);

    always_comb begin
        next_state = state;
        case (state)
            RST_WAIT: next_state = FETCH;
            FETCH: begin
                if (imem_ready)   next_state = DECODE;
                else if (timeout) next_state = HALT;
            end
            DECODE: next_state = (!is_legal || is_system) ? HALT : EXEC;
            EXEC: begin
                if (is_load || is_store)       next_state = MEM;
                else if (is_branch || is_fence) next_state = FETCH;
                else                            next_state = WB;
            end
            MEM: begin
                if (dmem_ready)   next_state = is_store ? FETCH : WB;
                else if (timeout) next_state = HALT;
            end
            WB:      next_state = FETCH;
            HALT:    next_state = HALT;
            default: next_state = RST_WAIT;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 2'b00;
        pc_we    = 1'b0;
        pc_sel   = 2'b00;
        retire   = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            EXEC: begin
                if (is_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = alu_cond ? 2'b01 : 2'b00;
                    retire = 1'b1;
                end else if (is_fence) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready && is_store) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            WB: begin
                reg_we = wb_reg;
                pc_we  = 1'b1;
                retire = 1'b1;
                if (is_load)                wb_sel = 2'b01;
                else if (is_jal || is_jalr) wb_sel = 2'b10;
                if (is_jal)       pc_sel = 2'b01;
                else if (is_jalr) pc_sel = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_WAIT;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state <= next_state;
            // The wait counter only measures time spent inside one FETCH or MEM visit.
            if (next_state != state) wait_cnt <= '0;
            else if (mem_wait)       wait_cnt <= wait_cnt + 1'b1;
            if ((state == DECODE) && !is_legal) illegal_q <= 1'b1;
            if (timeout)                        bus_err_q <= 1'b1;
            if (retire)                         instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
    assign halted  = (state == HALT);
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state_o = state;

endmodule
